// File: rtl/pgm_wr_if.sv
// pgm_wr_if: pipeline flit/PHV, PGM RAM write port and cfg-path signals of the PGM write stage.
interface pgm_wr_if;
    localparam int unsigned PHV_W  = 1024;
    localparam int unsigned FLIT_W = 134;
    localparam int unsigned RAM_AW = 7;
    localparam int unsigned RAM_DW = 144;

    // upstream pipeline
    logic [PHV_W-1:0]  in_wr_phv;
    logic              in_wr_phv_wr;
    logic              out_wr_phv_alf;
    logic [FLIT_W-1:0] in_wr_data;
    logic              in_wr_data_wr;
    logic              in_wr_valid;
    logic              in_wr_valid_wr;
    logic              out_wr_alf;

    // read stage
    logic [PHV_W-1:0]  out_wr_phv;
    logic              out_wr_phv_wr;
    logic              in_wr_phv_alf;
    logic [FLIT_W-1:0] out_wr_data;
    logic              out_wr_data_wr;
    logic              out_wr_valid;
    logic              out_wr_valid_wr;
    logic              in_wr_alf;
    logic              pgm_bypass_flag;
    logic              pgm_sent_start_flag;
    logic              pgm_sent_finish_flag;

    // PGM RAM write port
    logic              wr2ram_wr;
    logic [RAM_AW-1:0] wr2ram_addr;
    logic [RAM_DW-1:0] wr2ram_wdata;

    // configuration packet path
    logic [FLIT_W-1:0] cin_wr_data;
    logic              cin_wr_data_wr;
    logic              cout_wr_ready;
    logic [FLIT_W-1:0] cout_wr_data;
    logic              cout_wr_data_wr;
    logic              cin_wr_ready;

    modport slave (
        input  in_wr_phv, in_wr_phv_wr, in_wr_phv_alf,
        input  in_wr_data, in_wr_data_wr, in_wr_valid, in_wr_valid_wr, in_wr_alf,
        input  cin_wr_data, cin_wr_data_wr, cin_wr_ready,
        output out_wr_phv_alf, out_wr_alf, out_wr_phv, out_wr_phv_wr,
        output out_wr_data, out_wr_data_wr, out_wr_valid, out_wr_valid_wr,
        output pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag,
        output wr2ram_wr, wr2ram_addr, wr2ram_wdata,
        output cout_wr_ready, cout_wr_data, cout_wr_data_wr
    );

    modport master (
        output in_wr_phv, in_wr_phv_wr, in_wr_phv_alf,
        output in_wr_data, in_wr_data_wr, in_wr_valid, in_wr_valid_wr, in_wr_alf,
        output cin_wr_data, cin_wr_data_wr, cin_wr_ready,
        input  out_wr_phv_alf, out_wr_alf, out_wr_phv, out_wr_phv_wr,
        input  out_wr_data, out_wr_data_wr, out_wr_valid, out_wr_valid_wr,
        input  pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag,
        input  wr2ram_wr, wr2ram_addr, wr2ram_wdata,
        input  cout_wr_ready, cout_wr_data, cout_wr_data_wr
    );
endinterface

// File: rtl/pgm_wr.sv
// pgm_wr: PGM write stage. Captures one store packet into the PGM RAM, forwards all other
// traffic to the read stage, and runs the bypass/start/finish mode flags from cfg writes.
module pgm_wr #(
    parameter             PLATFORM = "Xilinx",
    parameter logic [7:0] LMID     = 8'd60,
    parameter logic [7:0] NMID     = 8'd61
) (
    input  logic    clk,
    input  logic    rst,
    pgm_wr_if.slave bus
);
    localparam int unsigned PHV_W  = 1024;
    localparam int unsigned FLIT_W = 134;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned RAM_DW = 144;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned CNT_W  = 32;

    localparam logic [1:0] HDR_HEAD = 2'b01;
    localparam logic [1:0] HDR_TAIL = 2'b10;
    localparam logic [2:0] CFG_WR   = 3'b010;
    localparam logic [2:0] CFG_RD   = 3'b001;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        STORE = 5'b00010,
        READY = 5'b00100,
        SEND  = 5'b01000,
        FIN   = 5'b10000
    } state_e;

    // Vendor tag and downstream ID are informational only
    if (PLATFORM == '0 && NMID == LMID) begin : g_info_params
    end

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [LEN_W-1:0]    stored_len_q, stored_len_d;
    logic [CNT_W-1:0]    ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic                err_start_q, err_start_d;
    logic                discard_q, discard_d;

    logic [PHV_W-1:0]    out_phv_q, out_phv_d;
    logic                out_phv_wr_q, out_phv_wr_d;
    logic [FLIT_W-1:0]   out_data_q, out_data_d;
    logic                out_data_wr_q, out_data_wr_d;
    logic                out_valid_q, out_valid_d;
    logic                out_valid_wr_q, out_valid_wr_d;
    logic                bypass_q, bypass_d;
    logic                start_q, start_d;
    logic                finish_q, finish_d;
    logic                ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [RAM_DW-1:0]   ram_wdata_q, ram_wdata_d;
    logic [FLIT_W-1:0]   cout_data_q, cout_data_d;
    logic                cout_data_wr_q, cout_data_wr_d;

    logic                cfg_head_c, cfg_wr_c, cfg_rd_c, ctrl_wr_c;
    logic                soft_rst_c, start_c, finish_c;
    logic [31:0]         cfg_addr_c, cfg_wdata_c, rd_val_c;
    logic [1:0]          flit_type_c;
    logic                store_head_c, fwd_ok_c;

    // Cfg header decode and software control strobes
    assign cfg_head_c  = bus.cin_wr_data_wr && bus.cin_wr_ready &&
                         (bus.cin_wr_data[133:132] == HDR_HEAD) &&
                         (bus.cin_wr_data[103:96] == LMID);
    assign cfg_wr_c    = cfg_head_c && (bus.cin_wr_data[126:124] == CFG_WR);
    assign cfg_rd_c    = cfg_head_c && (bus.cin_wr_data[126:124] == CFG_RD);
    assign cfg_addr_c  = bus.cin_wr_data[95:64];
    assign cfg_wdata_c = bus.cin_wr_data[31:0];
    assign ctrl_wr_c   = cfg_wr_c && (cfg_addr_c == 32'd0);
    assign soft_rst_c  = ctrl_wr_c && cfg_wdata_c[0];
    assign start_c     = ctrl_wr_c && cfg_wdata_c[1];
    assign finish_c    = ctrl_wr_c && cfg_wdata_c[2];

    // Pipeline flit classification; store/overflow/dropped packets are never forwarded
    assign flit_type_c  = bus.in_wr_data[133:132];
    assign store_head_c = bus.in_wr_data_wr && (flit_type_c == HDR_HEAD) &&
                          (bus.in_wr_data[103:96] == LMID);
    assign fwd_ok_c     = (state_q != STORE) && !discard_q && !store_head_c;

    // Register-map read mux
    always_comb begin
        rd_val_c = 32'hffff_ffff;
        case (cfg_addr_c)
            32'd0:   rd_val_c = {29'b0, finish_q, start_q, bypass_q};
            32'd1:   rd_val_c = {27'b0, state_q};
            32'd2:   rd_val_c = 32'(stored_len_q);
            32'd3:   rd_val_c = ovf_cnt_q;
            32'd4:   rd_val_c = drop_cnt_q;
            32'd5:   rd_val_c = {31'b0, err_start_q};
            default: rd_val_c = 32'hffff_ffff;
        endcase
    end

    // Next-state, RAM write, pass-through and flag logic
    always_comb begin
        state_d        = state_q;
        wr_addr_d      = wr_addr_q;
        stored_len_d   = stored_len_q;
        ovf_cnt_d      = ovf_cnt_q;
        drop_cnt_d     = drop_cnt_q;
        err_start_d    = err_start_q;
        discard_d      = discard_q;
        out_phv_d      = bus.in_wr_phv;
        out_phv_wr_d   = bus.in_wr_phv_wr && (state_q != STORE);
        out_data_d     = bus.in_wr_data;
        out_data_wr_d  = bus.in_wr_data_wr && fwd_ok_c;
        out_valid_d    = bus.in_wr_valid;
        out_valid_wr_d = bus.in_wr_valid_wr && fwd_ok_c;
        ram_wr_d       = 1'b0;
        ram_addr_d     = wr_addr_q;
        ram_wdata_d    = {10'b0, bus.in_wr_data};

        // Software start/finish act before the store decision so a same-cycle finish wins
        if (start_c) begin
            if (state_q == READY) begin
                state_d = SEND;
            end else if (state_q == IDLE) begin
                err_start_d = 1'b1;
            end
        end
        if (finish_c && (state_q == SEND)) begin
            state_d = FIN;
        end

        if (bus.in_wr_data_wr) begin
            if (state_q == STORE) begin
                ram_wr_d = 1'b1;
                if (flit_type_c == HDR_TAIL) begin
                    stored_len_d = LEN_W'(wr_addr_q) + LEN_W'(1);
                    state_d      = READY;
                end else if (wr_addr_q == '1) begin
                    // RAM full: close the stored packet here and drop the rest of it
                    ram_wdata_d  = {10'b0, HDR_TAIL, bus.in_wr_data[131:0]};
                    stored_len_d = LEN_W'(wr_addr_q) + LEN_W'(1);
                    discard_d    = 1'b1;
                    state_d      = READY;
                    if (ovf_cnt_q != '1) begin
                        ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
                    end
                end else begin
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                end
            end else if (discard_q) begin
                if (flit_type_c == HDR_TAIL) begin
                    discard_d = 1'b0;
                end
            end else if (store_head_c) begin
                if ((state_d == IDLE) || (state_d == READY)) begin
                    ram_wr_d   = 1'b1;
                    ram_addr_d = '0;
                    wr_addr_d  = ADDR_W'(1);
                    state_d    = STORE;
                end else begin
                    drop_cnt_d = drop_cnt_q + CNT_W'(1);
                    discard_d  = 1'b1;
                end
            end
        end

        bypass_d = (state_d == IDLE);
        start_d  = (state_d == SEND) || (state_d == FIN);
        finish_d = (state_d == FIN);

        // Soft reset clears the write stage; the cfg path keeps forwarding so the write propagates
        if (soft_rst_c) begin
            state_d        = IDLE;
            wr_addr_d      = '0;
            stored_len_d   = '0;
            ovf_cnt_d      = '0;
            discard_d      = 1'b0;
            out_phv_d      = '0;
            out_phv_wr_d   = 1'b0;
            out_data_d     = '0;
            out_data_wr_d  = 1'b0;
            out_valid_d    = 1'b0;
            out_valid_wr_d = 1'b0;
            ram_wr_d       = 1'b0;
            ram_addr_d     = '0;
            ram_wdata_d    = '0;
            bypass_d       = 1'b1;
            start_d        = 1'b0;
            finish_d       = 1'b0;
        end
    end

    // Cfg forwarding; reads replace the opcode nibble and data field
    always_comb begin
        cout_data_d    = bus.cin_wr_data;
        cout_data_wr_d = bus.cin_wr_data_wr;
        if (cfg_rd_c) begin
            cout_data_d = {bus.cin_wr_data[133:128], 4'b1011, bus.cin_wr_data[123:32], rd_val_c};
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_addr_q      <= '0;
            stored_len_q   <= '0;
            ovf_cnt_q      <= '0;
            drop_cnt_q     <= '0;
            err_start_q    <= 1'b0;
            discard_q      <= 1'b0;
            out_phv_q      <= '0;
            out_phv_wr_q   <= 1'b0;
            out_data_q     <= '0;
            out_data_wr_q  <= 1'b0;
            out_valid_q    <= 1'b0;
            out_valid_wr_q <= 1'b0;
            bypass_q       <= 1'b1;
            start_q        <= 1'b0;
            finish_q       <= 1'b0;
            ram_wr_q       <= 1'b0;
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
            cout_data_q    <= '0;
            cout_data_wr_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_addr_q      <= wr_addr_d;
            stored_len_q   <= stored_len_d;
            ovf_cnt_q      <= ovf_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
            err_start_q    <= err_start_d;
            discard_q      <= discard_d;
            out_phv_q      <= out_phv_d;
            out_phv_wr_q   <= out_phv_wr_d;
            out_data_q     <= out_data_d;
            out_data_wr_q  <= out_data_wr_d;
            out_valid_q    <= out_valid_d;
            out_valid_wr_q <= out_valid_wr_d;
            bypass_q       <= bypass_d;
            start_q        <= start_d;
            finish_q       <= finish_d;
            ram_wr_q       <= ram_wr_d;
            ram_addr_q     <= ram_addr_d;
            ram_wdata_q    <= ram_wdata_d;
            cout_data_q    <= cout_data_d;
            cout_data_wr_q <= cout_data_wr_d;
        end
    end

    assign bus.out_wr_phv_alf       = bus.in_wr_phv_alf;
    assign bus.out_wr_alf           = bus.in_wr_alf;
    assign bus.cout_wr_ready        = bus.cin_wr_ready;
    assign bus.out_wr_phv           = out_phv_q;
    assign bus.out_wr_phv_wr        = out_phv_wr_q;
    assign bus.out_wr_data          = out_data_q;
    assign bus.out_wr_data_wr       = out_data_wr_q;
    assign bus.out_wr_valid         = out_valid_q;
    assign bus.out_wr_valid_wr      = out_valid_wr_q;
    assign bus.pgm_bypass_flag      = bypass_q;
    assign bus.pgm_sent_start_flag  = start_q;
    assign bus.pgm_sent_finish_flag = finish_q;
    assign bus.wr2ram_wr            = ram_wr_q;
    assign bus.wr2ram_addr          = ram_addr_q;
    assign bus.wr2ram_wdata         = ram_wdata_q;
    assign bus.cout_wr_data         = cout_data_q;
    assign bus.cout_wr_data_wr      = cout_data_wr_q;
endmodule

// File: doc/pgm_wr.md
Name: pgm_wr

Overview:
- Packet-generator write stage, directly upstream of the PGM read/transmit stage.
- Captures one "store" packet from the pipeline into the 128x144 PGM RAM.
- Forwards all other packets and PHVs to the read stage with 1-cycle latency.
- Drives the bypass/start/finish flags the read stage consumes, under software control over the configuration packet path.

Parameters:
PLATFORM, "Xilinx", target vendor tag (no functional effect)
LMID, 8'd60, own module ID; matched against head-flit [103:96] (store packets) and cfg packets
NMID, 8'd61, downstream module ID (informational)

Ports:
clk  in  1  the single clock
rst  in  1  synchronous, active-high reset
in_wr_phv / in_wr_phv_wr  in  1024 / 1  PHV and strobe from upstream
out_wr_phv_alf  out  1  = in_wr_phv_alf, combinational
in_wr_data / in_wr_data_wr / in_wr_valid / in_wr_valid_wr  in  134/1/1/1  packet flits; [133:132] 01 head, 11 body, 10 tail; [131:128] valid bytes
out_wr_alf  out  1  = in_wr_alf, combinational
out_wr_phv / out_wr_phv_wr  out  1024 / 1  PHV to read stage, registered
in_wr_phv_alf  in  1  read-stage PHV almost-full
out_wr_data / out_wr_data_wr / out_wr_valid / out_wr_valid_wr  out  134/1/1/1  flits to read stage, registered
in_wr_alf  in  1  read-stage data almost-full
pgm_bypass_flag / pgm_sent_start_flag / pgm_sent_finish_flag  out  1 each  mode flags, registered
wr2ram_wr / wr2ram_addr / wr2ram_wdata  out  1/7/144  RAM write port; wdata = {10'b0, flit}
cin_wr_data / cin_wr_data_wr  in  134 / 1  cfg packet from DMA
cout_wr_ready  out  1  = cin_wr_ready, combinational
cout_wr_data / cout_wr_data_wr  out  134 / 1  cfg packet to next module, registered
cin_wr_ready  in  1  downstream cfg ready

Behaviour:
- Reset (rst=1 at clk edge), or soft_rst, clears:
  - all registered outputs to 0, except pgm_bypass_flag = 1;
  - state to IDLE;
  - wr_addr, stored_len and ovf_cnt to 0.
- soft_rst is a 1-cycle self-clearing pulse.
- States: IDLE (bypass=1), STORE, READY (bypass=0, start=0), SEND (start=1), FIN (start=1, finish=1). Exactly one state is active.
- Store packet: head flit with in_wr_data_wr=1, [133:132]=01 and [103:96]=LMID.
  - Accepted only in IDLE or READY; a new one overwrites the old, writing from addr 0 → STORE.
  - In SEND or FIN it is dropped whole (not forwarded, not written) and drop_cnt++.
- STORE:
  - Each flit is written at wr_addr (wr2ram_wr=1, one cycle after the input flit); wr_addr++.
  - Tail flit → stored_len = wr_addr+1, then READY.
  - Flit arriving at wr_addr=127 that is not a tail: written with [133:132] forced to 10; remaining flits of that packet are discarded; ovf_cnt++ (saturating 32-bit); → READY.
  - No flit or PHV is forwarded during STORE.
- Pass-through: every non-store flit/PHV is copied to the out_* ports one cycle later, unchanged, in any state. wr strobes are 0 when idle.
- Software start (ctrl bit1 written 1):
  - In READY → SEND.
  - Ignored elsewhere, except in IDLE, where it sets err_start (sticky, readable).
- Software finish (ctrl bit2 written 1) in SEND → FIN.
- FIN holds until soft_rst or rst, then → IDLE.
- Cfg path: head flit with cin_wr_data_wr=1 and cin_wr_ready=1, [133:132]=01, [103:96]=LMID.
  - [126:124]=010 is a write; [126:124]=001 is a read. Address is [95:64], data is [31:0].
  - Writes are forwarded unchanged, 1-cycle latency.
  - Reads return {hdr[133:128], 4'b1011, hdr[123:32], value}; unmapped addresses return 32'hffffffff.
  - All other flits are forwarded unchanged, 1-cycle latency.
- Register map:
  - 0x0 ctrl (W: bit0 soft_rst, bit1 start, bit2 finish; R: {29'b0, finish, start, bypass})
  - 0x1 state (one-hot, 5 bits)
  - 0x2 stored_len
  - 0x3 ovf_cnt
  - 0x4 drop_cnt
  - 0x5 err_start
- Simultaneous events:
  - A cfg finish and a store-packet head in the same cycle: the finish takes effect, and the store packet is dropped.
  - Reset mid-STORE: partial packet abandoned, and stored_len = 0.

Test Plan:
1. rst high 2 cycles, then a 3-flit non-store packet (dst 8'd5) → appears on out_wr_data 1 cycle later; bypass=1; wr2ram_wr never asserted.
2. 5-flit store packet (dst 8'd60) → wr2ram_addr 0..4 with [133:132] 01,11,11,11,10; stored_len=5; state READY; no out_wr_data_wr pulses.
3. Cfg write 0x0=0x2, then 0x0=0x4 → start rises one cycle after the cfg head; finish rises after the second write; read of 0x0 returns 0x6, with [127:124]=1011.
4. 140-flit store packet → 128 writes; addr 127 carries header 10; ovf_cnt=1; stored_len=128.
5. Store packet during SEND → dropped, drop_cnt=1, RAM untouched; unmapped cfg read 0x7 returns 32'hffffffff.
6. soft_rst via cfg during FIN → IDLE next cycle, bypass=1, stored_len=0.
